// File: rtl/ext_obi_addr_demux.sv
// ----------------------------------------------------------------------------
// ext_obi_addr_demux
//
// Parametrised OBI 1-to-N address demultiplexer. One master port is fanned out
// to NSLAVE slave ports. The target slave is decoded from the address either by
// a list of address rules (range mode) or by word-interleaving across all
// slaves inside rule 0's range (interleave mode). Accepted-but-unanswered
// transactions are counted, and a new request is held off while it would go
// to a different slave than the one still owing responses, so responses
// always return in request order.
//
// Optional feature macro: EXT_OBI_DEMUX_ERR_RESP_EN
//   defined   : unmapped addresses are served by an internal error slave
//               (grant at once, one cycle later rvalid with rdata 0xBADACCE5
//               and master_err_o = 1).
//   undefined : unmapped addresses are routed to slave 0; master_err_o = 0.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   master_req_i / master_gnt_o   master request handshake
//   master_addr_i, master_we_i,
//   master_be_i, master_wdata_i   master request payload
//   master_rvalid_o, master_rdata_o,
//   master_err_o                  master response
//   slave_req_o / slave_gnt_i     one-hot slave request, per-slave grant
//   slave_addr_o, slave_we_o,
//   slave_be_o, slave_wdata_o     request payload broadcast to all slaves
//   slave_rvalid_i, slave_rdata_i per-slave response (slave k data at
//                                 [k*DATA_WIDTH +: DATA_WIDTH])
//   outstanding_o                 current outstanding transaction count
// ----------------------------------------------------------------------------

package ext_obi_addr_demux_pkg;
  // Address rule: addresses in [start_addr, end_addr) map to slave idx.
  // Fields are 64 bits wide so one type serves any ADDR_WIDTH up to 64.
  typedef struct packed {
    logic [31:0] idx;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } addr_map_rule_t;
endpackage

module ext_obi_addr_demux
  import ext_obi_addr_demux_pkg::*;
#(
  parameter int unsigned NSLAVE          = 6,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned INTERLEAVE      = 0,
  parameter addr_map_rule_t [NSLAVE-1:0] ADDR_RULES = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  master_req_i,
  output logic                                  master_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                 master_addr_i,
  input  logic                                  master_we_i,
  input  logic [DATA_WIDTH/8-1:0]               master_be_i,
  input  logic [DATA_WIDTH-1:0]                 master_wdata_i,
  output logic                                  master_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 master_rdata_o,
  output logic                                  master_err_o,
  output logic [NSLAVE-1:0]                     slave_req_o,
  input  logic [NSLAVE-1:0]                     slave_gnt_i,
  output logic [ADDR_WIDTH-1:0]                 slave_addr_o,
  output logic                                  slave_we_o,
  output logic [DATA_WIDTH/8-1:0]               slave_be_o,
  output logic [DATA_WIDTH-1:0]                 slave_wdata_o,
  input  logic [NSLAVE-1:0]                     slave_rvalid_i,
  input  logic [NSLAVE*DATA_WIDTH-1:0]          slave_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int unsigned SEL_W = $clog2(NSLAVE + 1);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Select value NSLAVE stands for "no slave matched".
  localparam logic [SEL_W-1:0] SEL_UNMAPPED = SEL_W'(NSLAVE);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(MAX_OUTSTANDING);

  logic [SEL_W-1:0]      dec_sel;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      target;
  logic [CNT_W-1:0]      count;
  logic                  stall;
  logic                  accept;
  logic                  rsp_vld_raw;
  logic [DATA_WIDTH-1:0] rsp_data_raw;
  logic                  resp_valid;
  logic [63:0]           addr_ext;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign addr_ext  = 64'(master_addr_i);
  assign word_addr = master_addr_i >> OFF_W;

  // Payload is broadcast unmodified; only req selects the slave.
  assign slave_addr_o  = master_addr_i;
  assign slave_we_o    = master_we_i;
  assign slave_be_o    = master_be_i;
  assign slave_wdata_o = master_wdata_i;

  // Address decode
  always_comb begin
    dec_sel = SEL_UNMAPPED;
    if (INTERLEAVE != 0) begin
      if ((addr_ext >= ADDR_RULES[0].start_addr) && (addr_ext < ADDR_RULES[0].end_addr))
        dec_sel = SEL_W'(32'(word_addr[IDX_W-1:0]) % NSLAVE);
    end else begin
      // Walk from the highest rule down so the lowest-numbered match wins.
      for (int i = NSLAVE - 1; i >= 0; i--) begin
        if ((ADDR_RULES[i].idx < NSLAVE) &&
            (addr_ext >= ADDR_RULES[i].start_addr) &&
            (addr_ext <  ADDR_RULES[i].end_addr))
          dec_sel = SEL_W'(ADDR_RULES[i].idx);
      end
    end
  end

`ifdef EXT_OBI_DEMUX_ERR_RESP_EN
  assign sel = dec_sel;
`else
  assign sel = (dec_sel == SEL_UNMAPPED) ? '0 : dec_sel;
`endif

  // A response in the same cycle frees a slot, so a full tracker can still
  // accept. Switching slaves waits until every outstanding response is back.
  assign stall = ((count != '0) && (sel != target)) ||
                 ((count == CNT_MAX) && !resp_valid);

  always_comb begin
    slave_req_o  = '0;
    master_gnt_o = 1'b0;
    if (!stall) begin
      for (int k = 0; k < NSLAVE; k++) begin
        if (sel == SEL_W'(k)) begin
          slave_req_o[k] = master_req_i;
          master_gnt_o   = slave_gnt_i[k];
        end
      end
`ifdef EXT_OBI_DEMUX_ERR_RESP_EN
      if (sel == SEL_UNMAPPED)
        master_gnt_o = master_req_i;
`endif
    end
  end

  assign accept = master_req_i & master_gnt_o;

  // Response path: only the registered target may answer.
`ifdef EXT_OBI_DEMUX_ERR_RESP_EN
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5);
  logic err_pending;
`endif

  always_comb begin
    rsp_vld_raw  = 1'b0;
    rsp_data_raw = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (target == SEL_W'(k)) begin
        rsp_vld_raw  = slave_rvalid_i[k];
        rsp_data_raw = slave_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`ifdef EXT_OBI_DEMUX_ERR_RESP_EN
    if (target == SEL_UNMAPPED) begin
      rsp_vld_raw  = err_pending;
      rsp_data_raw = ERR_RDATA;
    end
`endif
  end

  // Responses with nothing outstanding are stale (e.g. across a reset).
  assign resp_valid      = rsp_vld_raw & (count != '0);
  assign master_rvalid_o = resp_valid;
  assign master_rdata_o  = resp_valid ? rsp_data_raw : '0;
  assign outstanding_o   = count;

`ifdef EXT_OBI_DEMUX_ERR_RESP_EN
  assign master_err_o = resp_valid && (target == SEL_UNMAPPED);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_pending <= 1'b0;
    else         err_pending <= accept && (sel == SEL_UNMAPPED);
  end
`else
  assign master_err_o = 1'b0;
`endif

  // Transaction tracker
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target <= '0;
      count  <= '0;
    end else begin
      if (accept) target <= sel;
      case ({accept, resp_valid})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
